branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage resolver for IF-stage control-flow predictions. Computes each B-type branch's
//  real outcome and each predicted jalr's real target, then checks them against the predictions.
//  On a mispredict it raises PL_flush and pc_rollback for the IF pc mux.
//  It also returns the *_branch_failed training bundle to branch_predictor.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles PL_flush stays high per mispredict (>=1)
//  CNT_W         32  width of the branch and mispredict counters
// PORTS
//  clk                          in   1     clock; sole clock domain
//  rst                          in   1     reset, synchronous, active-high
//  valid_ex                     in   1     EX holds a real instruction (not a bubble)
//  PL_stall_ex                  in   1     EX stalled; its inputs are held
//  B_type_ex                    in   1     EX instr is a B-type branch
//  beq_ex,bne_ex,blt_ex         in   1     branch kind, one-hot when B_type_ex
//  bge_ex,bltu_ex,bgeu_ex       in   1     branch kind, one-hot when B_type_ex
//  jalr_ex                      in   1     EX instr is jalr
//  jalr_prediction_en_ex        in   1     jalr target was predicted in IF
//  pc_ex                        in   32    pc of the EX instr
//  imme_ex                      in   32    sign-extended immediate
//  rs1_data_ex, rs2_data_ex     in   32    forwarded operands
//  B_type_result_ex             in   1     direction IF used: 1 = taken
//  jalr_target_pred_ex          in   32    target IF used for jalr
//  PL_flush                     out  1     squash younger stages; IF loads pc_rollback
//  pc_rollback                  out  32    corrected fetch pc
//  B_type_branch_failed         out  1     training strobe for a B-type mispredict
//  beq_..bgeu_branch_failed     out  1     registered kind flags (6 ports)
//  pc_branch_filled             out  32    pc of the failed branch
//  B_type_result_branch_failed  out  1     actual outcome of the failed branch
//  branch_cnt, mispredict_cnt   out  CNT_W saturating performance counters
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE and flush counter=0, starting the edge after rst is sampled high.
//    rst overrides every other input, including mid-flush.
//  eval = valid_ex & ~PL_stall_ex & (state==IDLE).
//    Each held instruction is evaluated exactly once, in the cycle its stall drops.
//  Actual outcome:
//    beq  =  rs1 == rs2          bne  =  rs1 != rs2
//    blt  =  signed  rs1 <  rs2  bge  =  signed  rs1 >= rs2
//    bltu =  unsigned rs1 <  rs2 bgeu =  unsigned rs1 >= rs2
//    Kind flags not one-hot -> actual = 0 (not taken).
//  B-type mispredict = eval & B_type_ex & (actual != B_type_result_ex).
//    Rollback = actual ? pc_ex+imme_ex : pc_ex+4, mod 2^32.
//  jalr mispredict = eval & jalr_ex & jalr_prediction_en_ex & (tgt != jalr_target_pred_ex),
//    where tgt = (rs1+imme) & 32'hFFFF_FFFE.
//    Rollback = tgt. Unpredicted jalr is never a mispredict.
//  FSM states:
//    IDLE : on a mispredict at edge N, register rollback/training data; go to FLUSH with cnt=FLUSH_CYCLES-1.
//    FLUSH: PL_flush=1 and pc_rollback held, from cycle N+1 for exactly FLUSH_CYCLES cycles.
//           valid_ex and PL_stall_ex are ignored (wrong-path). cnt==0 -> IDLE, else cnt--.
//  Training bundle: high only in the first FLUSH cycle, and only for B-type mispredicts.
//    pc_branch_filled and B_type_result_branch_failed are valid in that cycle; they are 0 otherwise.
//  Latency: mispredict resolved at edge N -> PL_flush in cycle N+1, registered with no comb path to outputs.
//  Counters, updated only on eval:
//    branch_cnt +1 on each B-type or predicted jalr.
//    mispredict_cnt +1 on each mispredict.
//    Both saturate at all-ones; no wrap.
// TESTING
//  1. beq, rs1=rs2=5, pc=0x100, imm=0x20, pred=0:
//     next cycle PL_flush=1, pc_rollback=0x120, beq_branch_failed=1,
//     B_type_result_branch_failed=1, pc_branch_filled=0x100.
//  2. blt, rs1=0xFFFFFFFF, rs2=1, pred=1: no flush.
//     Same operands as bltu, pred=1, pc=0x200: flush, pc_rollback=0x204, result_failed=0.
//  3. jalr predicted, pred=0x2000, rs1=0x3001, imm=0: flush, pc_rollback=0x3000, B_type_branch_failed=0.
//     Same case with jalr_prediction_en_ex=0: no flush.
//  4. Mispredicting bne held under PL_stall_ex for 3 cycles:
//     no flush while stalled, one flush after release, mispredict_cnt +1 only.
//  5. FLUSH_CYCLES=2: PL_flush high for exactly 2 cycles and training strobe for 1.
//     A mispredicting valid_ex during FLUSH is ignored.
//     rst asserted in the 1st flush cycle -> all outputs 0 next cycle.
//  6. CNT_W=4 with 20 mispredicts: mispredict_cnt=15 and branch_cnt=15, holding there.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage checker for IF-stage control-flow predictions.
//   Computes the real outcome of B-type branches and the real target of
//   predicted jalr instructions. On a mispredict it raises PL_flush and
//   pc_rollback for the IF pc mux, and returns a one-cycle training bundle to
//   the branch predictor. All outputs are registered.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_ex, PL_stall_ex       EX occupancy and stall
//   B_type_ex, beq..bgeu_ex     B-type flag and one-hot branch kind
//   jalr_ex, jalr_prediction_en_ex, jalr_target_pred_ex  jalr prediction info
//   pc_ex, imme_ex, rs1/rs2     EX pc, immediate and forwarded operands
//   B_type_result_ex            direction IF used (1 = taken)
//   PL_flush, pc_rollback       squash request and corrected fetch pc
//   *_branch_failed, pc_branch_filled, B_type_result_branch_failed  training bundle
//   branch_cnt, mispredict_cnt  saturating performance counters
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ex,
  input  logic             PL_stall_ex,
  input  logic             B_type_ex,
  input  logic             beq_ex,
  input  logic             bne_ex,
  input  logic             blt_ex,
  input  logic             bge_ex,
  input  logic             bltu_ex,
  input  logic             bgeu_ex,
  input  logic             jalr_ex,
  input  logic             jalr_prediction_en_ex,
  input  logic [31:0]      pc_ex,
  input  logic [31:0]      imme_ex,
  input  logic [31:0]      rs1_data_ex,
  input  logic [31:0]      rs2_data_ex,
  input  logic             B_type_result_ex,
  input  logic [31:0]      jalr_target_pred_ex,
  output logic             PL_flush,
  output logic [31:0]      pc_rollback,
  output logic             B_type_branch_failed,
  output logic             beq_branch_failed,
  output logic             bne_branch_failed,
  output logic             blt_branch_failed,
  output logic             bge_branch_failed,
  output logic             bltu_branch_failed,
  output logic             bgeu_branch_failed,
  output logic [31:0]      pc_branch_filled,
  output logic             B_type_result_branch_failed,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e             state_q, state_d;
  logic [FcW-1:0]     cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic [31:0]        roll_q, roll_d;
  logic               train_q, train_d;
  logic [5:0]         kind_q, kind_d;
  logic [31:0]        pcf_q, pcf_d;
  logic               res_q, res_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;

  logic [5:0]  kinds;
  logic        kind_onehot;
  logic        eq, lt_s, lt_u;
  logic        actual;
  logic        eval;
  logic        b_mis, j_mis;
  logic [31:0] b_target, seq_pc, jalr_tgt;

  // Bit order {beq, bne, blt, bge, bltu, bgeu}; same order as the training flags.
  assign kinds       = {beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex};
  assign kind_onehot = (kinds != 6'd0) && ((kinds & (kinds - 6'd1)) == 6'd0);

  assign eq   = (rs1_data_ex == rs2_data_ex);
  assign lt_s = ($signed(rs1_data_ex) < $signed(rs2_data_ex));
  assign lt_u = (rs1_data_ex < rs2_data_ex);

  // Malformed kind encodings resolve as not taken.
  always_comb begin
    actual = 1'b0;
    if (kind_onehot) begin
      unique case (kinds)
        6'b100000: actual = eq;
        6'b010000: actual = ~eq;
        6'b001000: actual = lt_s;
        6'b000100: actual = ~lt_s;
        6'b000010: actual = lt_u;
        6'b000001: actual = ~lt_u;
        default:   actual = 1'b0;
      endcase
    end
  end

  assign b_target = pc_ex + imme_ex;
  assign seq_pc   = pc_ex + 32'd4;
  assign jalr_tgt = (rs1_data_ex + imme_ex) & 32'hFFFF_FFFE;

  // Wrong-path instructions arriving during a flush are never evaluated.
  assign eval  = valid_ex & ~PL_stall_ex & (state_q == StIdle);
  assign b_mis = eval & B_type_ex & (actual != B_type_result_ex);
  assign j_mis = eval & ~B_type_ex & jalr_ex & jalr_prediction_en_ex &
                 (jalr_tgt != jalr_target_pred_ex);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    roll_d  = 32'd0;
    train_d = 1'b0;
    kind_d  = 6'd0;
    pcf_d   = 32'd0;
    res_d   = 1'b0;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;

    case (state_q)
      StIdle: begin
        if (eval && (B_type_ex || (jalr_ex && jalr_prediction_en_ex)) && (bcnt_q != '1)) begin
          bcnt_d = bcnt_q + CNT_W'(1);
        end
        if (b_mis || j_mis) begin
          if (mcnt_q != '1) begin
            mcnt_d = mcnt_q + CNT_W'(1);
          end
          state_d = StFlush;
          cnt_d   = FcLast;
          flush_d = 1'b1;
          if (b_mis) begin
            roll_d  = actual ? b_target : seq_pc;
            train_d = 1'b1;
            kind_d  = kinds;
            pcf_d   = pc_ex;
            res_d   = actual;
          end else begin
            roll_d = jalr_tgt;
          end
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q - FcW'(1);
          flush_d = 1'b1;
          roll_d  = roll_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      roll_q  <= 32'd0;
      train_q <= 1'b0;
      kind_q  <= 6'd0;
      pcf_q   <= 32'd0;
      res_q   <= 1'b0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      roll_q  <= roll_d;
      train_q <= train_d;
      kind_q  <= kind_d;
      pcf_q   <= pcf_d;
      res_q   <= res_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign PL_flush                    = flush_q;
  assign pc_rollback                 = roll_q;
  assign B_type_branch_failed        = train_q;
  assign beq_branch_failed           = kind_q[5];
  assign bne_branch_failed           = kind_q[4];
  assign blt_branch_failed           = kind_q[3];
  assign bge_branch_failed           = kind_q[2];
  assign bltu_branch_failed          = kind_q[1];
  assign bgeu_branch_failed          = kind_q[0];
  assign pc_branch_filled            = pcf_q;
  assign B_type_result_branch_failed = res_q;
  assign branch_cnt                  = bcnt_q;
  assign mispredict_cnt              = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (FLUSH_CYCLES=1/CNT_W=32 and
// FLUSH_CYCLES=2/CNT_W=4) share one stimulus stream; a per-instance model
// predicts every output cycle by cycle, plus directed literal checks.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_ex, PL_stall_ex, B_type_ex;
  logic        beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex;
  logic        jalr_ex, jalr_prediction_en_ex;
  logic [31:0] pc_ex, imme_ex, rs1_data_ex, rs2_data_ex, jalr_target_pred_ex;
  logic        B_type_result_ex;

  logic        flush_w [2];
  logic [31:0] roll_w  [2];
  logic        train_w [2];
  logic        k_w     [2][6];
  logic [31:0] pcf_w   [2];
  logic        res_w   [2];
  logic [31:0] bcnt0, mcnt0;
  logic [3:0]  bcnt1, mcnt1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_CYCLES(1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .valid_ex(valid_ex), .PL_stall_ex(PL_stall_ex),
    .B_type_ex(B_type_ex), .beq_ex(beq_ex), .bne_ex(bne_ex), .blt_ex(blt_ex),
    .bge_ex(bge_ex), .bltu_ex(bltu_ex), .bgeu_ex(bgeu_ex), .jalr_ex(jalr_ex),
    .jalr_prediction_en_ex(jalr_prediction_en_ex), .pc_ex(pc_ex), .imme_ex(imme_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .B_type_result_ex(B_type_result_ex), .jalr_target_pred_ex(jalr_target_pred_ex),
    .PL_flush(flush_w[0]), .pc_rollback(roll_w[0]), .B_type_branch_failed(train_w[0]),
    .beq_branch_failed(k_w[0][5]), .bne_branch_failed(k_w[0][4]),
    .blt_branch_failed(k_w[0][3]), .bge_branch_failed(k_w[0][2]),
    .bltu_branch_failed(k_w[0][1]), .bgeu_branch_failed(k_w[0][0]),
    .pc_branch_filled(pcf_w[0]), .B_type_result_branch_failed(res_w[0]),
    .branch_cnt(bcnt0), .mispredict_cnt(mcnt0)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .valid_ex(valid_ex), .PL_stall_ex(PL_stall_ex),
    .B_type_ex(B_type_ex), .beq_ex(beq_ex), .bne_ex(bne_ex), .blt_ex(blt_ex),
    .bge_ex(bge_ex), .bltu_ex(bltu_ex), .bgeu_ex(bgeu_ex), .jalr_ex(jalr_ex),
    .jalr_prediction_en_ex(jalr_prediction_en_ex), .pc_ex(pc_ex), .imme_ex(imme_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .B_type_result_ex(B_type_result_ex), .jalr_target_pred_ex(jalr_target_pred_ex),
    .PL_flush(flush_w[1]), .pc_rollback(roll_w[1]), .B_type_branch_failed(train_w[1]),
    .beq_branch_failed(k_w[1][5]), .bne_branch_failed(k_w[1][4]),
    .blt_branch_failed(k_w[1][3]), .bge_branch_failed(k_w[1][2]),
    .bltu_branch_failed(k_w[1][1]), .bgeu_branch_failed(k_w[1][0]),
    .pc_branch_filled(pcf_w[1]), .B_type_result_branch_failed(res_w[1]),
    .branch_cnt(bcnt1), .mispredict_cnt(mcnt1)
  );

  // ---------------- behavioural model ----------------
  int          fcs  [2] = '{1, 2};
  longint      cmax [2] = '{64'hFFFF_FFFF, 64'd15};
  int          left [2];
  bit          m_flush [2];
  logic [31:0] m_roll  [2];
  bit          m_train [2];
  bit   [5:0]  m_kind  [2];
  logic [31:0] m_pcf   [2];
  bit          m_res   [2];
  longint      m_b     [2];
  longint      m_m     [2];

  function automatic bit taken(bit [5:0] k, logic [31:0] a, logic [31:0] b);
    if ($countones(k) != 1) return 1'b0;
    if (k[5]) return a == b;
    if (k[4]) return a != b;
    if (k[3]) return $signed(a) < $signed(b);
    if (k[2]) return $signed(a) >= $signed(b);
    if (k[1]) return a < b;
    return a >= b;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        left[k] = 0; m_flush[k] = 0; m_roll[k] = 0; m_train[k] = 0; m_kind[k] = 0;
        m_pcf[k] = 0; m_res[k] = 0; m_b[k] = 0; m_m[k] = 0;
      end else begin
        bit [5:0]    kk;
        bit          act, bmis, jmis;
        logic [31:0] tgt;
        m_train[k] = 0; m_kind[k] = 0; m_pcf[k] = 0; m_res[k] = 0;
        if (left[k] > 0) begin
          left[k]--;
          m_flush[k] = (left[k] > 0);
          if (left[k] == 0) m_roll[k] = 0;
        end else begin
          m_flush[k] = 0;
          m_roll[k]  = 0;
          if (valid_ex && !PL_stall_ex) begin
            kk   = {beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex};
            act  = taken(kk, rs1_data_ex, rs2_data_ex);
            tgt  = (rs1_data_ex + imme_ex) & ~32'd1;
            bmis = B_type_ex && (act != B_type_result_ex);
            jmis = !B_type_ex && jalr_ex && jalr_prediction_en_ex && (tgt != jalr_target_pred_ex);
            if ((B_type_ex || (jalr_ex && jalr_prediction_en_ex)) && m_b[k] < cmax[k]) m_b[k]++;
            if (bmis || jmis) begin
              if (m_m[k] < cmax[k]) m_m[k]++;
              left[k]    = fcs[k];
              m_flush[k] = 1;
              m_roll[k]  = bmis ? (act ? pc_ex + imme_ex : pc_ex + 32'd4) : tgt;
              if (bmis) begin
                m_train[k] = 1; m_kind[k] = kk; m_pcf[k] = pc_ex; m_res[k] = act;
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit [5:0] kd;
        kd = {k_w[k][5], k_w[k][4], k_w[k][3], k_w[k][2], k_w[k][1], k_w[k][0]};
        chk($sformatf("m%0d_flush", k), 64'(flush_w[k]), 64'(m_flush[k]));
        chk($sformatf("m%0d_roll", k), 64'(roll_w[k]), 64'(m_roll[k]));
        chk($sformatf("m%0d_train", k), 64'(train_w[k]), 64'(m_train[k]));
        chk($sformatf("m%0d_kind", k), 64'(kd), 64'(m_kind[k]));
        chk($sformatf("m%0d_pcf", k), 64'(pcf_w[k]), 64'(m_pcf[k]));
        chk($sformatf("m%0d_res", k), 64'(res_w[k]), 64'(m_res[k]));
      end
      chk("m0_bcnt", 64'(bcnt0), m_b[0]);
      chk("m0_mcnt", 64'(mcnt0), m_m[0]);
      chk("m1_bcnt", 64'(bcnt1), m_b[1]);
      chk("m1_mcnt", 64'(mcnt1), m_m[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  task automatic set_b(bit [5:0] k, logic [31:0] pc, logic [31:0] imm,
                       logic [31:0] a, logic [31:0] b, bit pred);
    {beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex} = k;
    B_type_ex = 1; jalr_ex = 0; jalr_prediction_en_ex = 0;
    pc_ex = pc; imme_ex = imm; rs1_data_ex = a; rs2_data_ex = b;
    B_type_result_ex = pred; valid_ex = 1;
  endtask

  task automatic set_j(logic [31:0] pc, logic [31:0] imm, logic [31:0] a,
                       logic [31:0] jp, bit en);
    {beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex} = 6'd0;
    B_type_ex = 0; jalr_ex = 1; jalr_prediction_en_ex = en;
    pc_ex = pc; imme_ex = imm; rs1_data_ex = a; rs2_data_ex = 0;
    jalr_target_pred_ex = jp; valid_ex = 1;
  endtask

  task automatic fire();
    step();
    valid_ex = 0;
  endtask

  localparam bit [5:0] KBeq = 6'b100000, KBne = 6'b010000, KBlt = 6'b001000;
  localparam bit [5:0] KBge = 6'b000100, KBltu = 6'b000010, KBgeu = 6'b000001;

  bit   [5:0]  tk [10] = '{KBeq, KBne, KBlt, KBge, KBltu, KBgeu, KBlt, KBgeu, KBge, KBeq};
  logic [31:0] ta [10] = '{32'h8000_0000, 32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                           32'h0, 32'h5, 32'hFFFF_FFFF, 32'h5, 32'h1};
  logic [31:0] tb [10] = '{32'h8000_0000, 32'h7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                           32'h1, 32'h5, 32'hFFFF_FFFF, 32'h5, 32'h2};
  bit          tp [10] = '{0, 1, 0, 0, 1, 1, 1, 0, 1, 1};

  initial begin
    rst = 1; valid_ex = 0; PL_stall_ex = 0; B_type_ex = 0; jalr_ex = 0;
    jalr_prediction_en_ex = 0; {beq_ex, bne_ex, blt_ex, bge_ex, bltu_ex, bgeu_ex} = 6'd0;
    pc_ex = 0; imme_ex = 0; rs1_data_ex = 0; rs2_data_ex = 0; B_type_result_ex = 0;
    jalr_target_pred_ex = 0;
    step(); step();
    chk_en = 1;
    chk("rst_flush", 64'(flush_w[0]), 64'd0);
    chk("rst_bcnt", 64'(bcnt0), 64'd0);
    rst = 0;
    step();

    // 1: beq taken, predicted not taken
    set_b(KBeq, 32'h100, 32'h20, 5, 5, 0);
    fire();
    chk("t1_flush", 64'(flush_w[0]), 64'd1);
    chk("t1_roll", 64'(roll_w[0]), 64'h120);
    chk("t1_beq_failed", 64'(k_w[0][5]), 64'd1);
    chk("t1_res_failed", 64'(res_w[0]), 64'd1);
    chk("t1_pcf", 64'(pcf_w[0]), 64'h100);
    settle();

    // 2: blt signed taken (correct), bltu unsigned not taken (wrong)
    set_b(KBlt, 32'h180, 32'h40, 32'hFFFF_FFFF, 1, 1);
    fire();
    chk("t2_blt_noflush", 64'(flush_w[0]), 64'd0);
    settle();
    set_b(KBltu, 32'h200, 32'h40, 32'hFFFF_FFFF, 1, 1);
    fire();
    chk("t2_bltu_flush", 64'(flush_w[0]), 64'd1);
    chk("t2_bltu_roll", 64'(roll_w[0]), 64'h204);
    chk("t2_bltu_res", 64'(res_w[0]), 64'd0);
    settle();

    // 3: predicted jalr wrong, then unpredicted jalr
    set_j(32'h300, 0, 32'h3001, 32'h2000, 1);
    fire();
    chk("t3_jalr_flush", 64'(flush_w[0]), 64'd1);
    chk("t3_jalr_roll", 64'(roll_w[0]), 64'h3000);
    chk("t3_jalr_train", 64'(train_w[0]), 64'd0);
    settle();
    set_j(32'h300, 0, 32'h3001, 32'h2000, 0);
    fire();
    chk("t3_nopred_flush", 64'(flush_w[0]), 64'd0);
    settle();

    // 4: mispredicting bne held three cycles under stall
    set_b(KBne, 32'h500, 32'h8, 1, 2, 0);
    PL_stall_ex = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_noflush", 64'(flush_w[0]), 64'd0);
    end
    PL_stall_ex = 0;
    fire();
    chk("t4_flush", 64'(flush_w[0]), 64'd1);
    chk("t4_roll", 64'(roll_w[0]), 64'h508);
    settle();
    chk("t4_mcnt", 64'(mcnt0), 64'd4);
    chk("t4_bcnt", 64'(bcnt0), 64'd5);

    // Boundary operand table, checked by the model
    for (int i = 0; i < 10; i++) begin
      set_b(tk[i], 32'h1000 + 32'(i) * 16, 32'hFFFF_FFF0, ta[i], tb[i], tp[i]);
      fire();
      settle();
    end
    // Non-one-hot kind resolves not taken; pc+4 wraps to 0
    set_b(6'b110000, 32'hFFFF_FFFC, 32'h40, 3, 3, 1);
    fire();
    chk("bad_kind_flush", 64'(flush_w[0]), 64'd1);
    chk("wrap_roll", 64'(roll_w[0]), 64'd0);
    settle();

    // 5: two-cycle flush ignores wrong-path valid_ex
    set_b(KBeq, 32'h400, 32'h10, 7, 7, 0);
    fire();
    chk("t5_c1_flush", 64'(flush_w[1]), 64'd1);
    chk("t5_c1_train", 64'(train_w[1]), 64'd1);
    set_b(KBne, 32'h800, 32'h4, 1, 2, 0);
    step();
    valid_ex = 0;
    chk("t5_c2_flush", 64'(flush_w[1]), 64'd1);
    chk("t5_c2_train", 64'(train_w[1]), 64'd0);
    chk("t5_c2_roll", 64'(roll_w[1]), 64'h410);
    step();
    chk("t5_c3_flush", 64'(flush_w[1]), 64'd0);
    settle();
    // reset in the first flush cycle
    set_b(KBeq, 32'h400, 32'h10, 7, 7, 0);
    fire();
    rst = 1;
    step();
    chk("t5_rst_flush", 64'(flush_w[1]), 64'd0);
    chk("t5_rst_roll", 64'(roll_w[1]), 64'd0);
    chk("t5_rst_train", 64'(train_w[1]), 64'd0);
    chk("t5_rst_mcnt", 64'(mcnt0), 64'd0);
    rst = 0;
    step();

    // 6: 20 mispredicts saturate the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      set_b(KBeq, 32'h600, 32'h20, 9, 9, 0);
      fire();
      settle();
    end
    chk("t6_mcnt_sat", 64'(mcnt1), 64'd15);
    chk("t6_bcnt_sat", 64'(bcnt1), 64'd15);
    chk("t6_mcnt_wide", 64'(mcnt0), 64'd20);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
